// File: rtl/ext_bus_master_pkg.sv
// Shared constants and state encoding for the external bus master.
// The bench imports this package as well, so command codes stay in one place.
package ext_bus_master_pkg;
  localparam logic [7:0] CMD_READ     = 8'h02;
  localparam logic [7:0] CMD_WRITE    = 8'h03;
  localparam logic [7:0] CMD_ACK      = 8'h83;
  localparam logic [7:0] CMD_READ_ACK = 8'h82;
  localparam int         ADDR_BYTES   = 4;
  localparam int         DATA_BYTES   = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TX_CMD    = 3'd1,
    S_TX_ADDR   = 3'd2,
    S_TX_SEL    = 3'd3,
    S_TX_DATA   = 3'd4,
    S_WAIT_RESP = 3'd5,
    S_RX_DATA   = 3'd6,
    S_DONE      = 3'd7
  } state_e;
endpackage

// File: rtl/ext_bus_master_if.sv
// Requester handshake and external bus pins of the bus master.
// The master modport is the controller's view; slave is the requesters/device view.
interface ext_bus_master_if #(parameter int NUM_REQ = 2);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_we;
  logic [32*NUM_REQ-1:0] req_addr;
  logic [8*NUM_REQ-1:0]  req_sel;
  logic [64*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    resp_valid;
  logic                  resp_err;
  logic [63:0]           resp_rdata;
  logic [7:0]            ext_bus_out;
  logic                  ext_bus_pty_out;
  logic [7:0]            ext_bus_in;
  logic                  ext_bus_pty_in;
  logic                  parity_err;

  modport master (
    input  req_valid, req_we, req_addr, req_sel, req_wdata, ext_bus_in, ext_bus_pty_in,
    output req_ready, resp_valid, resp_err, resp_rdata, ext_bus_out, ext_bus_pty_out, parity_err
  );

  modport slave (
    output req_valid, req_we, req_addr, req_sel, req_wdata, ext_bus_in, ext_bus_pty_in,
    input  req_ready, resp_valid, resp_err, resp_rdata, ext_bus_out, ext_bus_pty_out, parity_err
  );
endinterface

// File: rtl/ext_bus_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from the pointer.
// The pointer only moves past the owner once that owner's transaction completes.
module ext_bus_rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               take,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_idx
);
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;

  // Walk offsets from farthest to nearest so the nearest pending request wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[IW'((int'(ptr_q) + i) % NUM_REQ)]) begin
        gnt = '0;
        gnt[IW'((int'(ptr_q) + i) % NUM_REQ)] = 1'b1;
        gnt_idx = IW'((int'(ptr_q) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    owner_d = (take && (gnt != '0)) ? gnt_idx : owner_q;
    ptr_d   = ptr_q;
    if (advance) ptr_d = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end
endmodule

// File: rtl/ext_bus_master.sv
// Host-side master for the 8-bit odd-parity external bus: arbitrates requesters,
// serializes one command at a time and returns ack, read data or error.
//
// state       | meaning
// S_IDLE      | bus idle, arbitrating among pending requesters
// S_TX_CMD    | driving command byte (write/read)
// S_TX_ADDR   | driving 4 address bytes, LSB first
// S_TX_SEL    | driving byte-lane select
// S_TX_DATA   | driving 8 write-data bytes, LSB first (writes only)
// S_WAIT_RESP | bus released, waiting for ack / read-ack / error byte
// S_RX_DATA   | collecting 8 read-data bytes, LSB first
// S_DONE      | response pulse to the owning requester
module ext_bus_master
  import ext_bus_master_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic               clk,
  input logic               rst,
  ext_bus_master_if.master  bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                we_q, we_d;
  logic [7:0]          sel_q, sel_d;
  logic [95:0]         tx_sh_q, tx_sh_d;
  logic [63:0]         rx_sh_q, rx_sh_d;
  logic [NUM_REQ-1:0]  owner_q, owner_d;
  logic [7:0]          out_q, out_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [63:0]         resp_rdata_q, resp_rdata_d;
  logic                parity_err_q, parity_err_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IW-1:0]       arb_idx;
  logic                pty_bad;
  logic                fin, fin_err;

  assign pty_bad = (bus.ext_bus_pty_in != ~^bus.ext_bus_in);

  ext_bus_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_valid),
    .take    (state_q == S_IDLE),
    .advance (state_q == S_DONE),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // tx_sh holds {wdata, addr}; the address drains first, sel is sent from its own
  // register, then the same shifter continues straight into the write data.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    we_d         = we_q;
    sel_d        = sel_q;
    tx_sh_d      = tx_sh_q;
    rx_sh_d      = rx_sh_q;
    owner_d      = owner_q;
    out_d        = 8'h00;
    req_ready_d  = '0;
    resp_valid_d = '0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    parity_err_d = parity_err_q | pty_bad;
    fin          = 1'b0;
    fin_err      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arb_gnt != '0) begin
          req_ready_d = arb_gnt;
          owner_d     = arb_gnt;
          we_d        = bus.req_we[arb_idx];
          sel_d       = bus.req_sel[8*arb_idx +: 8];
          tx_sh_d     = {bus.req_wdata[64*arb_idx +: 64], bus.req_addr[32*arb_idx +: 32]};
          out_d       = bus.req_we[arb_idx] ? CMD_WRITE : CMD_READ;
          state_d     = S_TX_CMD;
        end
      end
      S_TX_CMD: begin
        out_d   = tx_sh_q[7:0];
        tx_sh_d = tx_sh_q >> 8;
        cnt_d   = '0;
        state_d = S_TX_ADDR;
      end
      S_TX_ADDR: begin
        if (cnt_q == 4'(ADDR_BYTES - 1)) begin
          out_d   = sel_q;
          state_d = S_TX_SEL;
        end else begin
          out_d   = tx_sh_q[7:0];
          tx_sh_d = tx_sh_q >> 8;
          cnt_d   = cnt_q + 4'd1;
        end
      end
      S_TX_SEL: begin
        cnt_d = '0;
        if (we_q) begin
          out_d   = tx_sh_q[7:0];
          tx_sh_d = tx_sh_q >> 8;
          state_d = S_TX_DATA;
        end else begin
          tmo_d   = TW'(TIMEOUT_CYCLES - 1);
          state_d = S_WAIT_RESP;
        end
      end
      S_TX_DATA: begin
        if (cnt_q == 4'(DATA_BYTES - 1)) begin
          tmo_d   = TW'(TIMEOUT_CYCLES - 1);
          state_d = S_WAIT_RESP;
        end else begin
          out_d   = tx_sh_q[7:0];
          tx_sh_d = tx_sh_q >> 8;
          cnt_d   = cnt_q + 4'd1;
        end
      end
      S_WAIT_RESP: begin
        if (pty_bad || tmo_q == '0) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else if (bus.ext_bus_in == 8'h00) begin
          tmo_d = tmo_q - 1'b1;
        end else if (we_q && bus.ext_bus_in == CMD_ACK) begin
          fin = 1'b1;
        end else if (!we_q && bus.ext_bus_in == CMD_READ_ACK) begin
          cnt_d   = '0;
          tmo_d   = tmo_q - 1'b1;
          state_d = S_RX_DATA;
        end else begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end
      S_RX_DATA: begin
        if (pty_bad || tmo_q == '0) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          rx_sh_d = {bus.ext_bus_in, rx_sh_q[63:8]};
          if (cnt_q == 4'(DATA_BYTES - 1)) begin
            fin = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
            tmo_d = tmo_q - 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (fin) begin
      state_d      = S_DONE;
      resp_valid_d = owner_q;
      resp_err_d   = fin_err;
      resp_rdata_d = (fin_err || we_q) ? 64'h0 : rx_sh_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tmo_q        <= '0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      tx_sh_q      <= '0;
      rx_sh_q      <= '0;
      owner_q      <= '0;
      out_q        <= '0;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      tx_sh_q      <= tx_sh_d;
      rx_sh_q      <= rx_sh_d;
      owner_q      <= owner_d;
      out_q        <= out_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign bus.ext_bus_out     = out_q;
  assign bus.ext_bus_pty_out = ~^out_q;
  assign bus.req_ready       = req_ready_q;
  assign bus.resp_valid      = resp_valid_q;
  assign bus.resp_err        = resp_err_q;
  assign bus.resp_rdata      = resp_rdata_q;
  assign bus.parity_err      = parity_err_q;
endmodule

// File: tb/tb_ext_bus_master.sv
// Self-checking bench for ext_bus_master: a device model on the bus pins and a
// response scoreboard fed when each request is issued.
module tb_ext_bus_master;
  import ext_bus_master_pkg::*;

  localparam int TMO = 1024;

  typedef struct {
    int          owner;
    bit          err;
    logic [63:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ext_bus_master_if #(.NUM_REQ(2)) bus ();

  ext_bus_master #(.NUM_REQ(2), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  exp_t        sb[$];
  logic [7:0]  exp_bytes[$];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          busy  = 1'b0;
  int          rr    = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Response / grant monitor
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus.resp_valid != '0) begin
        if (sb.size() == 0) begin
          chk("resp_unexpected", 64'(bus.resp_valid), 64'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_owner", 64'(bus.resp_valid), 64'(1) << e.owner);
          chk("resp_err", 64'(bus.resp_err), 64'(e.err));
          chk("resp_rdata", bus.resp_rdata, e.rdata);
        end
        busy = 1'b0;
      end
      if (bus.req_ready != '0) begin
        chk("gnt_onehot", 64'($onehot(bus.req_ready)), 64'h1);
        chk("gnt_while_busy", 64'(busy), 64'h0);
        busy = 1'b1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int r, input bit we, input logic [31:0] a,
                         input logic [7:0] s, input logic [63:0] d);
    bus.req_we[r]            = we;
    bus.req_addr[32*r +: 32] = a;
    bus.req_sel[8*r +: 8]    = s;
    bus.req_wdata[64*r +: 64] = d;
  endtask

  task automatic fill_exp(input bit we, input logic [31:0] a, input logic [7:0] s,
                          input logic [63:0] d);
    exp_bytes.delete();
    exp_bytes.push_back(we ? CMD_WRITE : CMD_READ);
    for (int i = 0; i < 4; i++) exp_bytes.push_back(a[8*i +: 8]);
    exp_bytes.push_back(s);
    if (we) for (int i = 0; i < 8; i++) exp_bytes.push_back(d[8*i +: 8]);
  endtask

  task automatic dev_put(input logic [7:0] b, input bit flip);
    bus.ext_bus_in     = b;
    bus.ext_bus_pty_in = (~^b) ^ flip;
  endtask

  task automatic wait_grant(output int g);
    int w = 0;
    while (bus.req_ready == '0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (bus.req_ready[1])      g = 1;
    else if (bus.req_ready[0]) g = 0;
    else                       g = -1;
  endtask

  // Captures the serialized bytes; returns on the first WAIT_RESP cycle.
  task automatic dev_capture(input string tag);
    int w = 0;
    while (bus.ext_bus_out == 8'h00 && w < 50) begin
      @(negedge clk);
      w++;
    end
    foreach (exp_bytes[i]) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("%s_b%0d", tag, i), 64'(bus.ext_bus_out), 64'(exp_bytes[i]));
      chk($sformatf("%s_p%0d", tag, i), 64'(bus.ext_bus_pty_out), 64'(~^exp_bytes[i]));
    end
    @(negedge clk);
    chk($sformatf("%s_idle", tag), 64'(bus.ext_bus_out), 64'h0);
  endtask

  task automatic dev_ack();
    dev_put(CMD_ACK, 1'b0);
    @(negedge clk);
    dev_put(8'h00, 1'b0);
  endtask

  task automatic wait_sb();
    int w = 0;
    while (sb.size() > 0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("sb_drain", 64'(sb.size()), 64'h0);
  endtask

  logic [31:0] ta[2];
  logic [7:0]  ts[2];
  logic [63:0] td[2];
  int          g;
  int          lat;
  logic [1:0]  seen;

  initial begin
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_sel   = '0;
    bus.req_wdata = '0;
    dev_put(8'h00, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_out", 64'(bus.ext_bus_out), 64'h0);
    chk("rst_pty", 64'(bus.ext_bus_pty_out), 64'h1);
    chk("rst_ready", 64'(bus.req_ready), 64'h0);
    chk("rst_resp", 64'({bus.resp_valid, bus.resp_err}), 64'h0);
    chk("rst_rdata", bus.resp_rdata, 64'h0);
    chk("rst_perr", 64'(bus.parity_err), 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single write from requester 0
    set_req(0, 1'b1, 32'h1000_0004, 8'hFF, 64'h0123_4567_89AB_CDEF);
    bus.req_valid[0] = 1'b1;
    sb.push_back('{0, 1'b0, 64'h0});
    wait_grant(g);
    chk("wr_gnt", 64'(g), 64'h0);
    bus.req_valid[0] = 1'b0;
    fill_exp(1'b1, 32'h1000_0004, 8'hFF, 64'h0123_4567_89AB_CDEF);
    dev_capture("wr");
    dev_ack();
    wait_sb();
    rr = 1;

    // 2: read from requester 1
    set_req(1, 1'b0, 32'h0000_0020, 8'h0F, 64'h0);
    bus.req_valid[1] = 1'b1;
    sb.push_back('{1, 1'b0, 64'h8877_6655_4433_2211});
    wait_grant(g);
    chk("rd_gnt", 64'(g), 64'h1);
    bus.req_valid[1] = 1'b0;
    fill_exp(1'b0, 32'h0000_0020, 8'h0F, 64'h0);
    dev_capture("rd");
    dev_put(CMD_READ_ACK, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      dev_put(8'((k + 1) * 17), 1'b0);
    end
    @(negedge clk);
    dev_put(8'h00, 1'b0);
    wait_sb();
    rr = 0;

    // 3: both requesters held, grants must alternate
    ta[0] = 32'h0000_0100; ts[0] = 8'h01; td[0] = 64'hA0A1_A2A3_A4A5_A6A7;
    ta[1] = 32'h0000_0200; ts[1] = 8'h02; td[1] = 64'hB0B1_B2B3_B4B5_B6B7;
    set_req(0, 1'b1, ta[0], ts[0], td[0]);
    set_req(1, 1'b1, ta[1], ts[1], td[1]);
    bus.req_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      sb.push_back('{rr, 1'b0, 64'h0});
      wait_grant(g);
      chk($sformatf("arb_gnt%0d", t), 64'(g), 64'(rr));
      if (g < 0) g = rr;
      if (t == 3) bus.req_valid = 2'b00;
      fill_exp(1'b1, ta[g], ts[g], td[g]);
      dev_capture("arb");
      dev_ack();
      wait_sb();
      rr = (g + 1) % 2;
    end

    // 4: silent device after a write from requester 1
    set_req(1, 1'b1, 32'hDEAD_0000, 8'h3C, 64'h1111_2222_3333_4444);
    bus.req_valid[1] = 1'b1;
    sb.push_back('{1, 1'b1, 64'h0});
    wait_grant(g);
    chk("tmo_gnt", 64'(g), 64'h1);
    bus.req_valid[1] = 1'b0;
    fill_exp(1'b1, 32'hDEAD_0000, 8'h3C, 64'h1111_2222_3333_4444);
    dev_capture("tmo");
    lat = 0;
    while (bus.resp_valid == '0 && lat < TMO + 20) begin
      @(negedge clk);
      lat++;
    end
    chk("tmo_latency", 64'(lat), 64'(TMO));
    chk("tmo_bus", 64'(bus.ext_bus_out), 64'h0);
    wait_sb();
    rr = 0;

    // 5: parity flip on the third read data byte
    chk("pty_clean", 64'(bus.parity_err), 64'h0);
    set_req(0, 1'b0, 32'h0000_0044, 8'hF0, 64'h0);
    bus.req_valid[0] = 1'b1;
    sb.push_back('{0, 1'b1, 64'h0});
    wait_grant(g);
    chk("pty_gnt", 64'(g), 64'h0);
    bus.req_valid[0] = 1'b0;
    fill_exp(1'b0, 32'h0000_0044, 8'hF0, 64'h0);
    dev_capture("pty");
    dev_put(CMD_READ_ACK, 1'b0);
    @(negedge clk); dev_put(8'h11, 1'b0);
    @(negedge clk); dev_put(8'h22, 1'b0);
    @(negedge clk); dev_put(8'h33, 1'b1);
    @(negedge clk); dev_put(8'h00, 1'b0);
    wait_sb();
    rr = 1;
    chk("pty_sticky", 64'(bus.parity_err), 64'h1);
    repeat (5) @(negedge clk);
    chk("pty_sticky_later", 64'(bus.parity_err), 64'h1);

    // 6: reset during TX_ADDR, then arbitration restarts at requester 0
    set_req(1, 1'b1, 32'h5555_AAAA, 8'h81, 64'h0F0F_0F0F_0F0F_0F0F);
    bus.req_valid[1] = 1'b1;
    wait_grant(g);
    chk("rst_txn_gnt", 64'(g), 64'h1);
    bus.req_valid[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out", 64'(bus.ext_bus_out), 64'h0);
    chk("midrst_resp", 64'(bus.resp_valid), 64'h0);
    chk("midrst_perr", 64'(bus.parity_err), 64'h0);
    rst  = 1'b0;
    busy = 1'b0;
    rr   = 0;
    repeat (20) @(negedge clk);
    set_req(0, 1'b1, ta[0], ts[0], td[0]);
    set_req(1, 1'b1, ta[1], ts[1], td[1]);
    bus.req_valid = 2'b11;
    sb.push_back('{0, 1'b0, 64'h0});
    wait_grant(g);
    chk("post_rst_gnt", 64'(g), 64'h0);
    bus.req_valid = 2'b00;
    if (g < 0) g = 0;
    fill_exp(1'b1, ta[g], ts[g], td[g]);
    dev_capture("post");
    dev_ack();
    wait_sb();
    seen = '0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | bus.req_ready;
    end
    chk("withdrawn_req", 64'(seen), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
